perf_counter_collector: RTL

Consumer side of the per-operation performance counter handshake. It waits for a counter block to raise ready, then latches that block's latency sum and request count. It computes the average latency per request with a sequential restoring divider, updates running min/max/window statistics for slave-register readout, and returns the one-cycle copy-complete pulse that lets the counter clear its sum and restart.

---
 rtl/perf_counter_collector.sv | 132 +++++++++++++
 1 files changed

// File: rtl/perf_counter_collector.sv
// Consumer side of the performance-counter handshake: latches a finished window,
// divides latency sum by request count, keeps min/max/window stats and acks the counter.
module perf_counter_collector #(
  parameter int SUM_WD = 32,
  parameter int REQ_WD = 12,
  parameter int WIN_WD = 16
) (
  input  logic              i_bus_clk,
  input  logic              i_bus_rstn,
  input  logic              i_ready,
  input  logic [SUM_WD-1:0] i_cnt_sum,
  input  logic [REQ_WD-1:0] i_req_cnt,
  input  logic              i_stat_clr,
  output logic              o_cp_cmplt,
  output logic              o_busy,
  output logic [SUM_WD-1:0] o_avg,
  output logic              o_avg_valid,
  output logic [SUM_WD-1:0] o_min_avg,
  output logic [SUM_WD-1:0] o_max_avg,
  output logic [WIN_WD-1:0] o_win_cnt,
  output logic              o_div_zero
);

  localparam int ITER_WD = $clog2(SUM_WD);
  localparam logic [ITER_WD-1:0] LAST_ITER = ITER_WD'(SUM_WD - 1);

  typedef enum logic [2:0] {IDLE, DIVIDE, UPDATE, ACK, WAIT_DROP} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [SUM_WD-1:0]   quo_dvd;
  logic [REQ_WD-1:0]   divisor;
  logic [REQ_WD:0]     rem;
  logic [ITER_WD-1:0]  iter;
  logic                req_zero;
  logic [REQ_WD:0]     rem_shift;
  logic [REQ_WD:0]     rem_nxt;
  logic                quo_bit;
  logic                rem_top_unused;

  // quo_dvd shifts the dividend out of its MSB while quotient bits enter at the LSB.
  // The stored remainder is always below the divisor, so its top bit never matters.
  always_comb begin
    rem_shift = {rem[REQ_WD-1:0], quo_dvd[SUM_WD-1]};
    quo_bit   = (rem_shift >= {1'b0, divisor});
    rem_nxt   = quo_bit ? (rem_shift - {1'b0, divisor}) : rem_shift;
  end

  assign rem_top_unused = rem[REQ_WD];
  assign o_busy         = (state != IDLE);

  always_ff @(posedge i_bus_clk or negedge i_bus_rstn) begin
    if (!i_bus_rstn) state <= IDLE;
    else             state <= state_nxt;
  end

  // A zero divisor still spends one DIVIDE cycle so it is resolved from the latched register.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (i_ready) state_nxt = DIVIDE;
      DIVIDE:    if (req_zero || (iter == LAST_ITER)) state_nxt = UPDATE;
      UPDATE:    state_nxt = ACK;
      ACK:       state_nxt = WAIT_DROP;
      WAIT_DROP: if (!i_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_bus_clk or negedge i_bus_rstn) begin
    if (!i_bus_rstn) begin
      quo_dvd     <= '0;
      divisor     <= '0;
      rem         <= '0;
      iter        <= '0;
      req_zero    <= 1'b0;
      o_avg       <= '0;
      o_avg_valid <= 1'b0;
      o_cp_cmplt  <= 1'b0;
    end else begin
      o_avg_valid <= 1'b0;
      o_cp_cmplt  <= (state == ACK);
      case (state)
        IDLE: begin
          if (i_ready) begin
            quo_dvd  <= i_cnt_sum;
            divisor  <= i_req_cnt;
            rem      <= '0;
            iter     <= '0;
            req_zero <= (i_req_cnt == '0);
          end
        end
        DIVIDE: begin
          if (!req_zero) begin
            quo_dvd <= {quo_dvd[SUM_WD-2:0], quo_bit};
            rem     <= rem_nxt;
            iter    <= iter + ITER_WD'(1);
          end
        end
        UPDATE: begin
          o_avg       <= req_zero ? '0 : quo_dvd;
          o_avg_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A clear arriving together with UPDATE wins, dropping that window's statistics.
  always_ff @(posedge i_bus_clk or negedge i_bus_rstn) begin
    if (!i_bus_rstn) begin
      o_min_avg  <= '1;
      o_max_avg  <= '0;
      o_win_cnt  <= '0;
      o_div_zero <= 1'b0;
    end else if (i_stat_clr) begin
      o_min_avg  <= '1;
      o_max_avg  <= '0;
      o_win_cnt  <= '0;
      o_div_zero <= 1'b0;
    end else if (state == UPDATE) begin
      if (o_win_cnt != '1) o_win_cnt <= o_win_cnt + WIN_WD'(1);
      if (req_zero) begin
        o_div_zero <= 1'b1;
      end else begin
        if (quo_dvd < o_min_avg) o_min_avg <= quo_dvd;
        if (quo_dvd > o_max_avg) o_max_avg <= quo_dvd;
      end
    end
  end

endmodule
